// File: rtl/pll_lock_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer_pkg
// Shared definitions for the PLL lock sequencer: FSM state encoding and the
// state register width.
// ---------------------------------------------------------------------------
package pll_lock_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,  // PLL RESETB held low
    WAIT_LOCK = 3'd1,  // RESETB released, waiting for LOCK with timeout
    STABLE    = 3'd2,  // qualifying LOCK for a run of consecutive samples
    RUN       = 3'd3,  // system released, watching for lock loss
    FAULT     = 3'd4   // retries exhausted; left only through RESET
  } seq_state_t;

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer_if
// Bundles the PLL-facing and system-facing signals of the sequencer.
//   pll_lock    PLL LOCK (asynchronous to the reference clock)
//   pll_resetb  to PLL RESETB, active low
//   pll_bypass  to PLL BYPASS
//   sys_reset   active-high reset for downstream logic
//   locked      high while the sequencer is in RUN
//   fault       sticky fault flag
//   retry_cnt   failed attempts so far
// modport master: the sequencer; modport slave: PLL wrapper / system side.
// ---------------------------------------------------------------------------
interface pll_lock_sequencer_if;
  logic       pll_lock;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       sys_reset;
  logic       locked;
  logic       fault;
  logic [1:0] retry_cnt;

  modport master (
    input  pll_lock,
    output pll_resetb, pll_bypass, sys_reset, locked, fault, retry_cnt
  );

  modport slave (
    output pll_lock,
    input  pll_resetb, pll_bypass, sys_reset, locked, fault, retry_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer_sync_2ff
// Generic two-flop synchroniser, synchronous active-high reset to 0.
//   clk  destination clock
//   rst  synchronous active-high reset
//   d    asynchronous input
//   q    synchronised output (two cycles of latency)
// ---------------------------------------------------------------------------
module pll_lock_sequencer_sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: both stages use non-blocking assignments so each flop samples the
  // other's pre-edge value; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
// Brings up an SB_PLL40_CORE from the free-running reference clock: holds
// RESETB low, waits for LOCK with a timeout, qualifies lock stability, then
// releases the system reset. Lock loss or timeout re-runs the sequence; after
// MAX_RETRIES failed attempts the block parks in FAULT until RESET.
// Ports:
//   REFERENCECLK  reference clock (PLL input clock)
//   RESET         synchronous active-high reset
//   bus           pll_lock_sequencer_if.master (see interface for signals)
// Build option:
//   PLL_BYPASS_FALLBACK_EN  when defined, FAULT switches the PLL to bypass,
//   releases RESETB, and after RST_CYCLES releases sys_reset so the system
//   runs from the reference clock. Undefined: bypass tied low and FAULT holds
//   the PLL and system in reset.
// ---------------------------------------------------------------------------
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic                    REFERENCECLK,
  input  logic                    RESET,
  pll_lock_sequencer_if.master    bus
);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRIES - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;
  logic             fail_now;

  logic             pll_resetb_q;
  logic             sys_reset_q;
  logic             locked_q;
  logic             fault_q;
  logic [1:0]       retry_cnt_q;

  pll_lock_sequencer_sync_2ff #(.W(1)) u_lock_sync (
    .clk (REFERENCECLK),
    .rst (RESET),
    .d   (bus.pll_lock),
    .q   (lock_s)
  );

  // Both failure causes share one retry path. A lock that arrives on the
  // same cycle the timeout expires wins, hence the !lock_s term.
  assign fail_now = !lock_s &&
                    ((state == WAIT_LOCK && cnt == TIMEOUT_LAST) || state == RUN);

`ifdef PLL_BYPASS_FALLBACK_EN
  logic pll_bypass_q;
`endif

  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      state        <= PLL_RST;
      cnt          <= '0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
      retry_cnt_q  <= 2'd0;
`ifdef PLL_BYPASS_FALLBACK_EN
      pll_bypass_q <= 1'b0;
`endif
    end else if (fail_now) begin
      retry_cnt_q <= retry_cnt_q + 2'd1;
      cnt         <= '0;
      sys_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      if (retry_cnt_q == RETRY_LAST) begin
        state   <= FAULT;
        fault_q <= 1'b1;
`ifdef PLL_BYPASS_FALLBACK_EN
        pll_bypass_q <= 1'b1;
        pll_resetb_q <= 1'b1;
`else
        pll_resetb_q <= 1'b0;
`endif
      end else begin
        state        <= PLL_RST;
        pll_resetb_q <= 1'b0;
      end
    end else begin
      // Outputs change only on transitions; every transition clears cnt so
      // the single counter never carries over between states.
      unique case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            pll_resetb_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE: begin
          // A dropout only restarts qualification; it is not a failed attempt.
          if (!lock_s) begin
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            state       <= RUN;
            cnt         <= '0;
            sys_reset_q <= 1'b0;
            locked_q    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: begin
          cnt <= '0;
        end
        FAULT: begin
`ifdef PLL_BYPASS_FALLBACK_EN
          // Counter parks at RST_LAST once the bypassed system is released.
          if (cnt == RST_LAST) begin
            sys_reset_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
`else
          cnt <= '0;
`endif
        end
        default: begin
          state        <= PLL_RST;
          cnt          <= '0;
          pll_resetb_q <= 1'b0;
          sys_reset_q  <= 1'b1;
          locked_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_resetb = pll_resetb_q;
  assign bus.sys_reset  = sys_reset_q;
  assign bus.locked     = locked_q;
  assign bus.fault      = fault_q;
  assign bus.retry_cnt  = retry_cnt_q;
`ifdef PLL_BYPASS_FALLBACK_EN
  assign bus.pll_bypass = pll_bypass_q;
`else
  assign bus.pll_bypass = 1'b0;
`endif

endmodule
